// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: pipelined instruction fetch with an in-order prefetch buffer and redirect/kill handling.
// Define IF_PREDECODE_EN to enable predecode-driven predicted-jump redirects.
module if_prefetch_stage #(
  parameter int                 ADDR_W          = 64,
  parameter int                 INST_W          = 32,
  parameter int                 DATA_W          = 64,
  parameter int                 FIFO_DEPTH      = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0]  PC_RESET        = 'h80000000
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              excep_flush,
  input  logic [ADDR_W-1:0] excep_flush_pc,
  output logic [ADDR_W-1:0] pred_pc_o,
  input  logic              pred_jump_ena,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_pred_jump,
  output logic [ADDR_W-1:0] id_pred_target
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FP_W  = $clog2(FIFO_DEPTH);
  localparam int PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding, outstanding_nxt, count, kill_cnt;
  logic [CNT_W:0]    in_use;
  logic [FP_W-1:0]   wr_ptr, rd_ptr;
  logic [PQ_W-1:0]   pq_wr, pq_rd;
  logic [ADDR_W-1:0] pc_q [MAX_OUTSTANDING];
  logic [ADDR_W-1:0] fifo_pc [FIFO_DEPTH];
  logic [INST_W-1:0] fifo_inst [FIFO_DEPTH];
  logic              fifo_pj [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pt [FIFO_DEPTH];

  logic              resp_accept, resp_live, hard_redirect, pred_take, redirect;
  logic              issue, push, pop;
  logic [ADDR_W-1:0] redirect_pc;

  function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] p);
    return (p == PQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A response with nothing outstanding is stale (e.g. issued before a reset) and is ignored.
  assign resp_accept   = resp_valid && (outstanding != '0);
  assign resp_live     = resp_accept && (kill_cnt == '0);
  assign hard_redirect = excep_flush || flush;

`ifdef IF_PREDECODE_EN
  logic [6:0] resp_opcode;
  logic       resp_is_cti;
  assign resp_opcode = resp_data[6:0];
  assign resp_is_cti = (resp_opcode == 7'b1101111) || (resp_opcode == 7'b1100111) ||
                       (resp_opcode == 7'b1100011);
  assign pred_take   = resp_live && !hard_redirect && resp_is_cti && pred_jump_ena;
  assign pred_pc_o   = (outstanding != '0) ? pc_q[pq_rd] : '0;
`else
  logic unused_pred;
  assign unused_pred = pred_jump_ena;
  assign pred_take   = 1'b0;
  assign pred_pc_o   = '0;
`endif

  generate
    if (DATA_W > INST_W) begin : g_unused_hi
      logic unused_resp_hi;
      assign unused_resp_hi = ^resp_data[DATA_W-1:INST_W];
    end
  endgenerate

  assign redirect = hard_redirect || pred_take;

  always_comb begin
    redirect_pc = pred_target;
    if (excep_flush)
      redirect_pc = excep_flush_pc;
    else if (flush)
      redirect_pc = flush_addr;
  end

  // Slots are reserved at issue so every accepted response finds FIFO room.
  assign in_use    = {1'b0, outstanding} + {1'b0, count};
  assign req_valid = !cpu_rst && !redirect &&
                     (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                     (in_use < (CNT_W+1)'(FIFO_DEPTH));
  assign req_addr  = fetch_pc;
  assign issue     = req_valid && req_ready;
  assign push      = resp_live && !hard_redirect;
  assign id_valid  = (count != '0);
  assign pop       = id_valid && id_ready && !hard_redirect;

  assign outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(resp_accept);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_pc    <= PC_RESET;
      outstanding <= '0;
      count       <= '0;
      kill_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect)
        fetch_pc <= redirect_pc;
      else if (issue)
        fetch_pc <= fetch_pc + ADDR_W'(4);
      // Every request still in flight after a redirect is stale, including ones already marked.
      if (redirect)
        kill_cnt <= outstanding_nxt;
      else if (resp_accept && (kill_cnt != '0))
        kill_cnt <= kill_cnt - 1'b1;
      if (issue)
        pq_wr <= pq_next(pq_wr);
      if (resp_accept)
        pq_rd <= pq_next(pq_rd);
      if (hard_redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (issue)
      pc_q[pq_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]   <= pc_q[pq_rd];
      fifo_inst[wr_ptr] <= resp_data[INST_W-1:0];
      fifo_pj[wr_ptr]   <= pred_take;
      fifo_pt[wr_ptr]   <= pred_take ? pred_target : '0;
    end
  end

  assign id_pc          = id_valid ? fifo_pc[rd_ptr]   : '0;
  assign id_inst        = id_valid ? fifo_inst[rd_ptr] : '0;
  assign id_pred_jump   = id_valid ? fifo_pj[rd_ptr]   : 1'b0;
  assign id_pred_target = id_valid ? fifo_pt[rd_ptr]   : '0;

  a_outstanding_lim: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
    outstanding <= CNT_W'(MAX_OUTSTANDING));
  a_count_lim: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
    count <= CNT_W'(FIFO_DEPTH));
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: streaming, buffer fill, flush/exception redirects, predecode, reset.
module tb_if_prefetch_stage;
  localparam logic [63:0] PC0      = 64'h8000_0000;
  localparam logic [31:0] JAL_INST = 32'h1000_006F;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        flush, excep_flush;
  logic [63:0] flush_addr, excep_flush_pc;
  logic [63:0] pred_pc_o, pred_target;
  logic        pred_jump_ena;
  logic        id_valid, id_ready, id_pred_jump;
  logic [63:0] id_pc, id_pred_target;
  logic [31:0] id_inst;

  int n_cmp = 0;
  int n_fail = 0;
  int n_issued = 0;
  bit auto_resp = 1'b0;

  if_prefetch_stage dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .flush(flush), .flush_addr(flush_addr),
    .excep_flush(excep_flush), .excep_flush_pc(excep_flush_pc),
    .pred_pc_o(pred_pc_o), .pred_jump_ena(pred_jump_ena), .pred_target(pred_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_pred_jump(id_pred_jump), .id_pred_target(id_pred_target)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[26:2], 7'h13};
  endfunction

  // Entered and left at a falling edge; optionally models a bridge answering one cycle after issue.
  task automatic tick();
    bit iss;
    logic [63:0] a;
    #1;
    iss = req_valid && req_ready;
    a = req_addr;
    @(posedge cpu_clk_50M);
    #1;
    if (iss) n_issued++;
    if (auto_resp) begin
      resp_valid = iss;
      resp_data = {32'hDEAD_BEEF, inst_of(a)};
    end
    @(negedge cpu_clk_50M);
  endtask

  task automatic do_reset();
    @(negedge cpu_clk_50M);
    cpu_rst = 1; req_ready = 0; resp_valid = 0; resp_data = '0;
    flush = 0; flush_addr = '0; excep_flush = 0; excep_flush_pc = '0;
    pred_jump_ena = 0; pred_target = '0; id_ready = 0; auto_resp = 0; n_issued = 0;
    @(negedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    cpu_rst = 0;
  endtask

  task automatic test_reset();
    cpu_rst = 1; req_ready = 1; resp_valid = 0; resp_data = '0;
    flush = 0; flush_addr = '0; excep_flush = 0; excep_flush_pc = '0;
    pred_jump_ena = 0; pred_target = '0; id_ready = 1;
    #12;
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    n_cmp++; if (req_addr !== PC0) begin n_fail++; $display("FAIL rst_req_addr: got %h want %h", req_addr, PC0); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
    n_cmp++; if (pred_pc_o !== 64'h0) begin n_fail++; $display("FAIL rst_pred_pc: got %h want 0", pred_pc_o); end
  endtask

  task automatic test_sequential();
    do_reset();
    req_ready = 1; id_ready = 1; auto_resp = 1;
    #1;
    n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL seq_first_valid: got %b want 1", req_valid); end
    n_cmp++; if (req_addr !== PC0) begin n_fail++; $display("FAIL seq_addr0: got %h want %h", req_addr, PC0); end
    tick();
    n_cmp++; if (req_addr !== PC0 + 64'h4) begin n_fail++; $display("FAIL seq_addr1: got %h want %h", req_addr, PC0 + 64'h4); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_no_bypass: got %b want 0", id_valid); end
    tick();
    n_cmp++; if (req_addr !== PC0 + 64'h8) begin n_fail++; $display("FAIL seq_addr2: got %h want %h", req_addr, PC0 + 64'h8); end
    n_cmp++; if (id_pc !== PC0) begin n_fail++; $display("FAIL seq_id_pc0: got %h want %h", id_pc, PC0); end
    n_cmp++; if (id_inst !== inst_of(PC0)) begin n_fail++; $display("FAIL seq_id_inst0: got %h want %h", id_inst, inst_of(PC0)); end
    tick();
    n_cmp++; if (id_pc !== PC0 + 64'h4) begin n_fail++; $display("FAIL seq_id_pc1: got %h want %h", id_pc, PC0 + 64'h4); end
    tick();
    n_cmp++; if (id_pc !== PC0 + 64'h8) begin n_fail++; $display("FAIL seq_id_pc2: got %h want %h", id_pc, PC0 + 64'h8); end
  endtask

  task automatic test_fill();
    do_reset();
    req_ready = 1; id_ready = 0; auto_resp = 1;
    repeat (10) tick();
    n_cmp++; if (n_issued != 4) begin n_fail++; $display("FAIL fill_issued: got %0d want 4", n_issued); end
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL fill_req_valid: got %b want 0", req_valid); end
    id_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== PC0 + 64'(4 * i)) begin
        n_fail++; $display("FAIL fill_pop%0d: got v=%b pc=%h want v=1 pc=%h", i, id_valid, id_pc, PC0 + 64'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_ready = 1; id_ready = 1; auto_resp = 0;
    tick();
    tick();
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_limit: got %b want 0", req_valid); end
    flush = 1; flush_addr = PC0 + 64'h1000;
    tick();
    flush = 0; req_ready = 0;
    resp_valid = 1; resp_data = {32'h0, inst_of(PC0)};
    tick();
    resp_data = {32'h0, inst_of(PC0 + 64'h4)};
    tick();
    resp_valid = 0;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", id_valid); end
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== PC0 + 64'h1000) begin
      n_fail++; $display("FAIL flush_req: got v=%b a=%h want v=1 a=%h", req_valid, req_addr, PC0 + 64'h1000);
    end
    req_ready = 1; auto_resp = 1;
    tick();
    tick();
    n_cmp++; if (id_pc !== PC0 + 64'h1000) begin n_fail++; $display("FAIL flush_id_pc: got %h want %h", id_pc, PC0 + 64'h1000); end
    n_cmp++; if (id_inst !== inst_of(PC0 + 64'h1000)) begin n_fail++; $display("FAIL flush_id_inst: got %h want %h", id_inst, inst_of(PC0 + 64'h1000)); end
  endtask

  task automatic test_excep_priority();
    do_reset();
    req_ready = 1; id_ready = 1; auto_resp = 1;
    tick();
    tick();
    flush = 1; flush_addr = PC0 + 64'h1000;
    excep_flush = 1; excep_flush_pc = PC0 + 64'h200;
    tick();
    flush = 0; excep_flush = 0;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL excep_cleared: got %b want 0", id_valid); end
    n_cmp++; if (req_addr !== PC0 + 64'h200) begin n_fail++; $display("FAIL excep_addr: got %h want %h", req_addr, PC0 + 64'h200); end
    tick();
    tick();
    n_cmp++; if (id_pc !== PC0 + 64'h200) begin n_fail++; $display("FAIL excep_id_pc: got %h want %h", id_pc, PC0 + 64'h200); end
  endtask

`ifdef IF_PREDECODE_EN
  task automatic test_predecode();
    do_reset();
    req_ready = 1; id_ready = 1; auto_resp = 0;
    pred_jump_ena = 1; pred_target = PC0 + 64'h100;
    tick();
    tick();
    resp_valid = 1; resp_data = {32'h0, inst_of(PC0)};
    tick();
    resp_data = {32'h0, inst_of(PC0 + 64'h4)};
    tick();
    resp_valid = 0;
    tick();
    n_cmp++; if (pred_pc_o !== PC0 + 64'h8) begin n_fail++; $display("FAIL pd_pred_pc: got %h want %h", pred_pc_o, PC0 + 64'h8); end
    resp_valid = 1; resp_data = {32'h0, JAL_INST};
    tick();
    n_cmp++; if (id_pc !== PC0 + 64'h8 || id_pred_jump !== 1'b1) begin
      n_fail++; $display("FAIL pd_head: got pc=%h pj=%b want pc=%h pj=1", id_pc, id_pred_jump, PC0 + 64'h8);
    end
    n_cmp++; if (id_pred_target !== PC0 + 64'h100) begin n_fail++; $display("FAIL pd_target: got %h want %h", id_pred_target, PC0 + 64'h100); end
    n_cmp++; if (req_addr !== PC0 + 64'h100) begin n_fail++; $display("FAIL pd_req_addr: got %h want %h", req_addr, PC0 + 64'h100); end
    req_ready = 0; resp_data = {32'h0, inst_of(PC0 + 64'hC)};
    tick();
    resp_valid = 0;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL pd_killed: got %b want 0", id_valid); end
    pred_jump_ena = 0; req_ready = 1; auto_resp = 1;
    tick();
    tick();
    n_cmp++; if (id_pc !== PC0 + 64'h100 || id_pred_jump !== 1'b0) begin
      n_fail++; $display("FAIL pd_target_fetch: got pc=%h pj=%b want pc=%h pj=0", id_pc, id_pred_jump, PC0 + 64'h100);
    end
  endtask
`else
  task automatic test_no_predecode();
    do_reset();
    req_ready = 1; id_ready = 0; auto_resp = 0;
    pred_jump_ena = 1; pred_target = PC0 + 64'h100;
    tick();
    n_cmp++; if (pred_pc_o !== 64'h0) begin n_fail++; $display("FAIL npd_pred_pc: got %h want 0", pred_pc_o); end
    req_ready = 0; resp_valid = 1; resp_data = {32'h0, JAL_INST};
    tick();
    resp_valid = 0;
    n_cmp++; if (id_valid !== 1'b1 || id_inst !== JAL_INST) begin
      n_fail++; $display("FAIL npd_head: got v=%b inst=%h want v=1 inst=%h", id_valid, id_inst, JAL_INST);
    end
    n_cmp++; if (id_pred_jump !== 1'b0 || id_pred_target !== 64'h0) begin
      n_fail++; $display("FAIL npd_pred: got pj=%b pt=%h want 0/0", id_pred_jump, id_pred_target);
    end
    n_cmp++; if (req_addr !== PC0 + 64'h4) begin n_fail++; $display("FAIL npd_seq: got %h want %h", req_addr, PC0 + 64'h4); end
  endtask
`endif

  task automatic test_reset_midflight();
    do_reset();
    req_ready = 1; id_ready = 0; auto_resp = 1;
    tick();
    tick();
    auto_resp = 0;
    tick();
    resp_valid = 0;
    tick();
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b want 1", id_valid); end
    #1 cpu_rst = 1;
    #1;
    n_cmp++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_valid: got req=%b id=%b want 0/0", req_valid, id_valid);
    end
    n_cmp++; if (id_pc !== 64'h0 || id_inst !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_data: got pc=%h inst=%h want 0/0", id_pc, id_inst);
    end
    n_cmp++; if (req_addr !== PC0) begin n_fail++; $display("FAIL mid_rst_addr: got %h want %h", req_addr, PC0); end
    @(negedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    cpu_rst = 0; req_ready = 0;
    resp_valid = 1; resp_data = {32'h0, inst_of(PC0 + 64'h8)};
    tick();
    resp_valid = 0;
    tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b want 0", id_valid); end
    req_ready = 1; auto_resp = 1;
    tick();
    tick();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== PC0) begin
      n_fail++; $display("FAIL mid_restart: got v=%b pc=%h want v=1 pc=%h", id_valid, id_pc, PC0);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_flush();
    test_excep_priority();
`ifdef IF_PREDECODE_EN
    test_predecode();
`else
    test_no_predecode();
`endif
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
